// File: rtl/turn_move_judge.sv
// turn_move_judge: card pick, reveal window and match judging for the
// Chicken Cha-Cha-Cha board; advances players and hands turns to next_turn.
module turn_move_judge #(
    parameter int REVEAL_CYCLES = 8,
    parameter int TRACK_LEN     = 24,
    parameter int TURN_TIMEOUT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] N,
    input  logic [1:0] T,
    input  logic       go,
    input  logic [3:0] card_val,
    input  logic [3:0] target_val,
    output logic       statecombo_next_turn,
    output logic       reveal_on,
    output logic       move_ok,
    output logic       win,
    output logic [1:0] winner,
    output logic       turn_err,
    output logic [4:0] pos_cur
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GO,
        REVEAL,
        JUDGE,
        ADVANCE,
        PASS,
        WAIT_TURN,
        WIN_ST
    } state_t;

    localparam logic [7:0] REV_LOAD = 8'(REVEAL_CYCLES - 1);
    localparam logic [3:0] TO_LAST  = 4'(TURN_TIMEOUT - 1);
    localparam logic [4:0] TRACK    = 5'(TRACK_LEN);

    state_t     state;
    state_t     state_nxt;

    logic       go_d;
    logic       go_edge;
    logic [2:0] players;
    logic       turn_ok;

    logic [3:0] card_l;
    logic [1:0] turn_l;
    logic [7:0] rcnt;
    logic [3:0] tcnt;
    logic [4:0] pos [4];
    logic [4:0] adv_pos;

    logic       ld_card;
    logic       set_err;
    logic       clr_game;
    logic       adv;
    logic       dec_r;
    logic       clr_t;
    logic       inc_t;
    logic       to_win;

    assign go_edge = go & ~go_d;

    // Player count from the N code; 11 is treated as four players.
    always_comb begin
        players = 3'd4;
        if (N == 2'b00) begin
            players = 3'd2;
        end else if (N == 2'b01) begin
            players = 3'd3;
        end
    end

    assign turn_ok = ({1'b0, T} < players);

    // Next position of the latched player, saturating at the goal tile.
    always_comb begin
        adv_pos = pos[turn_l];
        if (pos[turn_l] < TRACK) begin
            adv_pos = pos[turn_l] + 5'd1;
        end
    end

    assign to_win = (adv_pos == TRACK);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the per-state strobes and outputs.
    always_comb begin
        state_nxt            = state;
        ld_card              = 1'b0;
        set_err              = 1'b0;
        clr_game             = 1'b0;
        adv                  = 1'b0;
        dec_r                = 1'b0;
        clr_t                = 1'b0;
        inc_t                = 1'b0;
        statecombo_next_turn = 1'b0;
        reveal_on            = 1'b0;
        move_ok              = 1'b0;
        win                  = 1'b0;
        case (state)
            IDLE: begin
                clr_game = 1'b1;
                if (go_edge) begin
                    state_nxt = WAIT_GO;
                end
            end
            WAIT_GO: begin
                if (go_edge) begin
                    if (turn_ok) begin
                        ld_card   = 1'b1;
                        state_nxt = REVEAL;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            REVEAL: begin
                reveal_on = 1'b1;
                if (rcnt == 8'd0) begin
                    state_nxt = JUDGE;
                end else begin
                    dec_r = 1'b1;
                end
            end
            JUDGE: begin
                if (card_l == target_val) begin
                    state_nxt = ADVANCE;
                end else begin
                    state_nxt = PASS;
                end
            end
            ADVANCE: begin
                move_ok = 1'b1;
                adv     = 1'b1;
                if (to_win) begin
                    state_nxt = WIN_ST;
                end else begin
                    state_nxt = WAIT_GO;
                end
            end
            PASS: begin
                statecombo_next_turn = 1'b1;
                clr_t                = 1'b1;
                state_nxt            = WAIT_TURN;
            end
            WAIT_TURN: begin
                if (T != turn_l) begin
                    state_nxt = WAIT_GO;
                end else if (tcnt == TO_LAST) begin
                    set_err   = 1'b1;
                    state_nxt = WAIT_GO;
                end else begin
                    inc_t = 1'b1;
                end
            end
            WIN_ST: begin
                win = 1'b1;
                if (go_edge) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Delayed go for edge detection; tracks go in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go_d <= 1'b0;
        end else begin
            go_d <= go;
        end
    end

    // Card and turn captured at the accepting go edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            card_l <= 4'd0;
            turn_l <= 2'd0;
        end else if (ld_card) begin
            card_l <= card_val;
            turn_l <= T;
        end
    end

    // Reveal window down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= 8'd0;
        end else if (ld_card) begin
            rcnt <= REV_LOAD;
        end else if (dec_r) begin
            rcnt <= rcnt - 8'd1;
        end
    end

    // Cycles spent waiting for next_turn to change T.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= 4'd0;
        end else if (clr_t) begin
            tcnt <= 4'd0;
        end else if (inc_t) begin
            tcnt <= tcnt + 4'd1;
        end
    end

    // Player positions: cleared while idle, bumped on a match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                pos[i] <= 5'd0;
            end
        end else if (clr_game) begin
            for (int i = 0; i < 4; i++) begin
                pos[i] <= 5'd0;
            end
        end else if (adv) begin
            pos[turn_l] <= adv_pos;
        end
    end

    // Sticky turn error, dropped only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turn_err <= 1'b0;
        end else if (clr_game) begin
            turn_err <= 1'b0;
        end else if (set_err) begin
            turn_err <= 1'b1;
        end
    end

    // Winner index captured on the winning advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner <= 2'd0;
        end else if (adv && to_win) begin
            winner <= turn_l;
        end
    end

    // Position display for the player whose turn it is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_cur <= 5'd0;
        end else begin
            pos_cur <= pos[T];
        end
    end

endmodule

// File: tb/tb_turn_move_judge.sv
// tb_turn_move_judge: directed scenarios plus randomized turns checked
// against a transaction-level game model.
module tb_turn_move_judge;

    localparam int R  = 8;
    localparam int TL = 24;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] N = 2'd0;
    logic [1:0] T = 2'd0;
    logic       go = 1'b0;
    logic [3:0] card_val = 4'd0;
    logic [3:0] target_val = 4'd0;
    logic       statecombo_next_turn;
    logic       reveal_on;
    logic       move_ok;
    logic       win;
    logic [1:0] winner;
    logic       turn_err;
    logic [4:0] pos_cur;

    int n_tests = 0;
    int n_fail  = 0;

    int mpos [4];
    bit merr;
    bit mwin;
    int mwinner;

    turn_move_judge #(
        .REVEAL_CYCLES(R),
        .TRACK_LEN(TL),
        .TURN_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .N(N),
        .T(T),
        .go(go),
        .card_val(card_val),
        .target_val(target_val),
        .statecombo_next_turn(statecombo_next_turn),
        .reveal_on(reveal_on),
        .move_ok(move_ok),
        .win(win),
        .winner(winner),
        .turn_err(turn_err),
        .pos_cur(pos_cur)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int players(input logic [1:0] n);
        if (n == 2'd0) return 2;
        if (n == 2'd1) return 3;
        return 4;
    endfunction

    task automatic model_clear;
        for (int i = 0; i < 4; i++) mpos[i] = 0;
        merr = 1'b0;
        mwin = 1'b0;
        mwinner = 0;
    endtask

    task automatic go_pulse;
        go = 1'b1;
        tick;
        go = 1'b0;
        tick;
    endtask

    task automatic check_pos;
        for (int k = 0; k < 4; k++) begin
            T = 2'(k);
            tick;
            check($sformatf("pos[%0d]", k), int'(pos_cur), mpos[k]);
        end
    endtask

    // One go press in WAIT_GO, watched for long enough to cover a timeout.
    task automatic do_turn(input logic [1:0] t, input logic [3:0] card,
                           input logic [3:0] tgt, input bit respond,
                           input int dly);
        int np;
        int nrev;
        int first_rev;
        int nok;
        int ok_at;
        int nreq;
        int req_at;
        bit valid;
        bit match;
        np = players(N);
        nrev = 0;
        first_rev = -1;
        nok = 0;
        ok_at = -1;
        nreq = 0;
        req_at = -1;
        valid = int'(t) < np;
        match = (card == tgt);
        T = t;
        card_val = card;
        target_val = tgt ^ 4'h9;
        go = 1'b1;
        tick;
        go = 1'b0;
        card_val = ~card;
        target_val = tgt;
        for (int c = 1; c <= R + TO + 6; c++) begin
            if (reveal_on) begin
                nrev++;
                if (first_rev < 0) first_rev = c;
            end
            if (move_ok) begin
                nok++;
                if (ok_at < 0) ok_at = c;
            end
            if (statecombo_next_turn) begin
                nreq++;
                if (req_at < 0) req_at = c;
            end
            if (respond && req_at > 0 && c == req_at + dly)
                T = 2'((int'(t) + 1) % np);
            tick;
        end
        if (!valid) begin
            merr = 1'b1;
            check("bad_turn_reveal", nrev, 0);
            check("bad_turn_move", nok, 0);
            check("bad_turn_req", nreq, 0);
        end else begin
            check("reveal_len", nrev, R);
            check("reveal_start", first_rev, 1);
            if (match) begin
                check("move_cnt", nok, 1);
                check("move_lat", ok_at, R + 2);
                check("match_req", nreq, 0);
                if (mpos[t] < TL) mpos[t]++;
                if (mpos[t] == TL) begin
                    mwin = 1'b1;
                    mwinner = int'(t);
                end
            end else begin
                check("miss_move", nok, 0);
                check("req_cnt", nreq, 1);
                check("req_lat", req_at, R + 2);
                if (!respond) merr = 1'b1;
            end
        end
        check("turn_err", int'(turn_err), int'(merr));
        check("win", int'(win), int'(mwin));
        if (mwin) check("winner", int'(winner), mwinner);
    endtask

    // Leave WIN through IDLE and come back to WAIT_GO.
    task automatic finish_win;
        check("err_before_idle", int'(turn_err), int'(merr));
        go_pulse;
        model_clear;
        check("win_clear", int'(win), 0);
        check("err_idle", int'(turn_err), 0);
        check_pos;
        go_pulse;
    endtask

    initial begin
        int nrev;
        int nreq;
        int np;
        logic [1:0] t;
        logic [3:0] cv;
        logic [3:0] tv;
        model_clear;

        tick;
        tick;
        check("rst_req", int'(statecombo_next_turn), 0);
        check("rst_reveal", int'(reveal_on), 0);
        check("rst_move", int'(move_ok), 0);
        check("rst_win", int'(win), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_err", int'(turn_err), 0);
        check("rst_pos", int'(pos_cur), 0);
        rst = 1'b0;
        tick;

        // out-of-range turn with go held high
        go_pulse;
        N = 2'b00;
        T = 2'd3;
        nrev = 0;
        go = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (reveal_on) nrev++;
        end
        go = 1'b0;
        tick;
        if (reveal_on) nrev++;
        check("oor_reveal", nrev, 0);
        check("oor_err", int'(turn_err), 1);

        // reset during reveal
        N = 2'b10;
        T = 2'd0;
        card_val = 4'd6;
        go = 1'b1;
        tick;
        go = 1'b0;
        tick;
        tick;
        tick;
        check("rev4_on", int'(reveal_on), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_reveal", int'(reveal_on), 0);
        check("mid_rst_req", int'(statecombo_next_turn), 0);
        check("mid_rst_err", int'(turn_err), 0);
        check("mid_rst_move", int'(move_ok), 0);
        nreq = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (statecombo_next_turn) nreq++;
        end
        rst = 1'b0;
        go_pulse;
        nrev = 0;
        for (int i = 0; i < R + 6; i++) begin
            if (reveal_on) nrev++;
            if (statecombo_next_turn) nreq++;
            tick;
        end
        check("post_rst_idle", nrev, 0);
        check("post_rst_req", nreq, 0);
        model_clear;

        // match, miss with handshake, miss with timeout
        N = 2'b10;
        do_turn(2'd1, 4'd5, 4'd5, 1'b0, 0);
        check_pos;
        do_turn(2'd0, 4'd3, 4'd7, 1'b1, 2);
        check_pos;
        do_turn(2'd1, 4'd4, 4'd4, 1'b0, 0);
        do_turn(2'd0, 4'd3, 4'd7, 1'b1, 1);
        do_turn(2'd0, 4'd3, 4'd7, 1'b0, 0);
        check_pos;

        // run player 2 to the goal
        N = 2'b10;
        for (int i = 0; i < TL; i++) begin
            cv = 4'($urandom_range(0, 15));
            do_turn(2'd2, cv, cv, 1'b0, 0);
        end
        check_pos;
        if (mwin) finish_win;
        else check("win_reached", 0, 1);

        // randomized turns
        for (int i = 0; i < 40; i++) begin
            N = 2'($urandom_range(0, 3));
            np = players(N);
            if ($urandom_range(0, 7) == 0) t = 2'($urandom_range(0, 3));
            else t = 2'($urandom_range(0, np - 1));
            cv = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) tv = cv;
            else tv = cv ^ 4'($urandom_range(1, 15));
            do_turn(t, cv, tv, 1'($urandom_range(0, 3) != 0),
                    $urandom_range(1, TO));
            check_pos;
            if (mwin) finish_win;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
